// File: rtl/gain_ramp_ctrl.sv
// rtl/gain_ramp_ctrl.sv - multi-channel gain ramp controller with mute and retarget
//
// Each channel holds a GW-bit gain code. When a request is accepted, the channel
// ramps toward the requested target by req_step. It takes one step every DWELL
// clock cycles and never overshoots the target.
//
// Ports:
//   clk, rst_n   single clock, synchronous active-low reset
//   req_valid    request strobe; accepted when req_ready is also high
//   req_ready    high whenever out of reset and not muted
//   req_ch       target channel index (values >= CHANNELS are rejected)
//   req_gain     target gain code
//   req_step     step size per dwell period; 0 jumps straight to the target
//   mute         forces every channel to gain 0 and idle
//   gain_out     registered gain codes, channel c at [c*GW +: GW]
//   busy         channel c is ramping
//   done         one-cycle pulse when channel c lands on its target
//   req_err      one-cycle pulse after a request to an out-of-range channel
module gain_ramp_ctrl #(
    parameter int CHANNELS   = 4,
    parameter int GW         = 8,
    parameter int STEP_W     = 4,
    parameter int DWELL      = 16,
    parameter int RESET_GAIN = 0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] req_ch,
    input  logic [GW-1:0]                       req_gain,
    input  logic [STEP_W-1:0]                   req_step,
    input  logic                                mute,
    output logic [CHANNELS*GW-1:0]              gain_out,
    output logic [CHANNELS-1:0]                 busy,
    output logic [CHANNELS-1:0]                 done,
    output logic                                req_err
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] RELOAD = DW'(DWELL - 1);
    localparam logic [GW-1:0] RST_G  = GW'(RESET_GAIN);

    typedef enum logic {IDLE, RAMP} state_t;

    state_t              state_q  [CHANNELS];
    state_t              state_d  [CHANNELS];
    logic [GW-1:0]       gain_q   [CHANNELS];
    logic [GW-1:0]       gain_d   [CHANNELS];
    logic [GW-1:0]       target_q [CHANNELS];
    logic [GW-1:0]       target_d [CHANNELS];
    logic [STEP_W-1:0]   step_q   [CHANNELS];
    logic [STEP_W-1:0]   step_d   [CHANNELS];
    logic [DW-1:0]       cnt_q    [CHANNELS];
    logic [DW-1:0]       cnt_d    [CHANNELS];
    logic [CHANNELS-1:0] done_q;
    logic [CHANNELS-1:0] done_d;
    logic                err_q;

    logic accept;
    logic ch_ok;

    assign req_ready = rst_n & ~mute;
    assign accept    = req_valid & req_ready;
    // One extra bit so CHANNELS itself is representable when it is a power of two.
    assign ch_ok     = ({1'b0, req_ch} < (CW+1)'(CHANNELS));

    // One step toward t, clamped at t. It is evaluated in GW+1 bits so that
    // neither 0 nor 2^GW-1 can wrap.
    function automatic logic [GW-1:0] step_toward(input logic [GW-1:0]     g,
                                                  input logic [GW-1:0]     t,
                                                  input logic [STEP_W-1:0] s);
        logic [GW:0] ge;
        logic [GW:0] te;
        logic [GW:0] se;
        ge = {1'b0, g};
        te = {1'b0, t};
        se = (GW+1)'(s);
        if (te > ge) begin
            return (te - ge <= se) ? t : GW'(ge + se);
        end else begin
            return (ge - te <= se) ? t : GW'(ge - se);
        end
    endfunction

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            state_d[c]  = state_q[c];
            gain_d[c]   = gain_q[c];
            target_d[c] = target_q[c];
            step_d[c]   = step_q[c];
            cnt_d[c]    = cnt_q[c];
            done_d[c]   = 1'b0;

            if (mute) begin
                state_d[c]  = IDLE;
                gain_d[c]   = '0;
                target_d[c] = '0;
                cnt_d[c]    = '0;
            end else if (accept && ch_ok && (req_ch == CW'(c))) begin
                // An accepted request overrides any step due on this edge.
                // The gain held before the edge is the new starting point.
                target_d[c] = req_gain;
                if (req_gain == gain_q[c]) begin
                    state_d[c] = IDLE;
                    done_d[c]  = 1'b1;
                end else if (req_step == '0) begin
                    gain_d[c]  = req_gain;
                    state_d[c] = IDLE;
                    done_d[c]  = 1'b1;
                end else begin
                    step_d[c]  = req_step;
                    cnt_d[c]   = RELOAD;
                    state_d[c] = RAMP;
                end
            end else if (state_q[c] == RAMP) begin
                if (cnt_q[c] != '0) begin
                    cnt_d[c] = cnt_q[c] - 1'b1;
                end else begin
                    gain_d[c] = step_toward(gain_q[c], target_q[c], step_q[c]);
                    cnt_d[c]  = RELOAD;
                    if (gain_d[c] == target_q[c]) begin
                        state_d[c] = IDLE;
                        done_d[c]  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c]  <= IDLE;
                gain_q[c]   <= RST_G;
                target_q[c] <= RST_G;
                step_q[c]   <= '0;
                cnt_q[c]    <= '0;
            end
            done_q <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c]  <= state_d[c];
                gain_q[c]   <= gain_d[c];
                target_q[c] <= target_d[c];
                step_q[c]   <= step_d[c];
                cnt_q[c]    <= cnt_d[c];
            end
            done_q <= done_d;
            err_q  <= accept & ~ch_ok;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_out
        assign gain_out[c*GW +: GW] = gain_q[c];
        assign busy[c]              = (state_q[c] == RAMP);
    end

    assign done    = done_q;
    assign req_err = err_q;

endmodule

// File: tb/tb_gain_ramp_ctrl.sv
// tb/tb_gain_ramp_ctrl.sv - directed and randomized bench for gain_ramp_ctrl
module tb_gain_ramp_ctrl;

    localparam int CH    = 3;
    localparam int DWELL = 4;
    localparam int RG    = 32;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_ch;
    logic [7:0]  req_gain;
    logic [3:0]  req_step;
    logic        mute;
    logic [23:0] gain_out;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic        req_err;

    gain_ramp_ctrl #(
        .CHANNELS(CH), .GW(8), .STEP_W(4), .DWELL(DWELL), .RESET_GAIN(RG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_ch(req_ch), .req_gain(req_gain), .req_step(req_step), .mute(mute),
        .gain_out(gain_out), .busy(busy), .done(done), .req_err(req_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: a ramping channel's next step is scheduled at an absolute
    // cycle number, DWELL cycles after the accept or after the previous step.
    int cyc = 0;
    int m_gain [CH];
    int m_tgt  [CH];
    int m_step [CH];
    int m_next [CH];
    bit m_ramp [CH];
    bit m_done [CH];
    bit m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        cyc++;
        m_err = 0;
        for (int c = 0; c < CH; c++) m_done[c] = 0;
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                m_gain[c] = RG; m_tgt[c] = RG; m_ramp[c] = 0;
            end
        end else if (mute) begin
            for (int c = 0; c < CH; c++) begin
                m_gain[c] = 0; m_tgt[c] = 0; m_ramp[c] = 0;
            end
        end else begin
            if (req_valid && int'(req_ch) >= CH) m_err = 1;
            for (int c = 0; c < CH; c++) begin
                if (req_valid && int'(req_ch) == c) begin
                    m_tgt[c] = req_gain;
                    if (int'(req_gain) == m_gain[c]) begin
                        m_ramp[c] = 0; m_done[c] = 1;
                    end else if (req_step == 0) begin
                        m_gain[c] = req_gain; m_ramp[c] = 0; m_done[c] = 1;
                    end else begin
                        m_step[c] = req_step; m_ramp[c] = 1; m_next[c] = cyc + DWELL;
                    end
                end else if (m_ramp[c] && cyc == m_next[c]) begin
                    if (m_tgt[c] > m_gain[c])
                        m_gain[c] = (m_tgt[c] - m_gain[c] <= m_step[c]) ? m_tgt[c] : m_gain[c] + m_step[c];
                    else
                        m_gain[c] = (m_gain[c] - m_tgt[c] <= m_step[c]) ? m_tgt[c] : m_gain[c] - m_step[c];
                    if (m_gain[c] == m_tgt[c]) begin
                        m_ramp[c] = 0; m_done[c] = 1;
                    end else begin
                        m_next[c] = m_next[c] + DWELL;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("gain%0d", c), 32'(gain_out[c*8 +: 8]), m_gain[c]);
            chk($sformatf("busy%0d", c), 32'(busy[c]), 32'(m_ramp[c]));
            chk($sformatf("done%0d", c), 32'(done[c]), 32'(m_done[c]));
        end
        chk("req_err", 32'(req_err), 32'(m_err));
        chk("req_ready", 32'(req_ready), 32'(rst_n & ~mute));
    endtask

    task automatic req(input int ch, input int g, input int s);
        req_valid = 1'b1;
        req_ch    = 2'(ch);
        req_gain  = 8'(g);
        req_step  = 4'(s);
        tick();
        req_valid = 1'b0;
    endtask

    int ramp_exp [4];
    int dn_exp   [3];

    initial begin
        ramp_exp = '{3, 6, 9, 10};
        dn_exp   = '{196, 192, 190};
        rst_n = 1'b0; mute = 1'b0; req_valid = 1'b0;
        req_ch = '0; req_gain = '0; req_step = '0;
        tick();
        req_valid = 1'b1; req_gain = 8'd77;
        tick();
        req_valid = 1'b0;
        chk("rst_gain1", 32'(gain_out[15:8]), RG);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(req_ready), 0);
        rst_n = 1'b1;

        // ch0 ramp 0 -> 10, step 3
        req(0, 0, 0);
        req(0, 10, 3);
        chk("ramp0_busy", 32'(busy[0]), 1);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k % 4 == 0) chk("ramp0_val", 32'(gain_out[7:0]), ramp_exp[k/4-1]);
        end
        chk("ramp0_done", 32'(done[0]), 1);
        chk("ramp0_idle", 32'(busy[0]), 0);
        tick();
        chk("ramp0_done_once", 32'(done[0]), 0);

        // ch1 ramp down 200 -> 190, step 4, clamped last step
        req(1, 200, 0);
        req(1, 190, 4);
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k % 4 == 0) chk("ramp1_val", 32'(gain_out[15:8]), dn_exp[k/4-1]);
        end
        chk("ramp1_done", 32'(done[1]), 1);
        chk("ramp1_ch0_kept", 32'(gain_out[7:0]), 10);

        // ch2 retarget mid-ramp with immediate jump
        req(2, 0, 0);
        req(2, 100, 5);
        repeat (12) tick();
        chk("retgt_at15", 32'(gain_out[23:16]), 15);
        req(2, 5, 0);
        chk("retgt_val", 32'(gain_out[23:16]), 5);
        chk("retgt_done", 32'(done[2]), 1);
        repeat (8) tick();

        // mute while two channels ramp
        req(0, 50, 2);
        req(1, 100, 7);
        repeat (5) tick();
        mute = 1'b1; req_valid = 1'b1; req_ch = 2'd0; req_gain = 8'd77; req_step = 4'd0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mute_gain", 32'(gain_out), 0);
            chk("mute_busy", 32'(busy), 0);
            chk("mute_ready", 32'(req_ready), 0);
        end
        mute = 1'b0; req_valid = 1'b0;
        repeat (6) tick();
        chk("mute_hold", 32'(gain_out), 0);
        req(0, 20, 0);
        chk("post_mute", 32'(gain_out[7:0]), 20);

        // out-of-range channel
        req(3, 9, 0);
        chk("err_pulse", 32'(req_err), 1);
        chk("err_gains", 32'(gain_out[7:0]), 20);
        tick();
        chk("err_once", 32'(req_err), 0);

        // reset mid-ramp
        req(0, 0, 0);
        req(0, 30, 3);
        repeat (12) tick();
        chk("rstmid_at9", 32'(gain_out[7:0]), 9);
        rst_n = 1'b0;
        tick();
        chk("rstmid_gain", 32'(gain_out), {8'(RG), 8'(RG), 8'(RG)});
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_done", 32'(done), 0);
        rst_n = 1'b1;
        req(0, RG, 5);
        chk("rstmid_eq_done", 32'(done[0]), 1);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            int ch;
            rst_n     = ($urandom_range(0, 149) != 0);
            mute      = ($urandom_range(0, 39) == 0);
            req_valid = ($urandom_range(0, 3) == 0);
            ch        = $urandom_range(0, 3);
            req_ch    = 2'(ch);
            case ($urandom_range(0, 7))
                0:       req_gain = 8'd0;
                1:       req_gain = 8'd255;
                2:       req_gain = (ch < CH) ? 8'(m_gain[ch]) : 8'd1;
                default: req_gain = 8'($urandom_range(0, 255));
            endcase
            req_step = 4'($urandom_range(0, 15));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
